// File: rtl/program_sequencer_stall_if.sv
// Program sequencer bus: decode inputs from the instruction
// decoder and ALU, fetch address and pc outputs back.
interface program_sequencer_stall_if #(
    parameter int PC_W = 8
);
    logic            jmp;
    logic            jmp_nz;
    logic [3:0]      jmp_addr;
    logic            dont_jmp;
    logic            NOPC8;
    logic            NOPCF;
    logic            NOPD8;
    logic            NOPDF;
    logic [PC_W-1:0] pm_addr;
    logic [PC_W-1:0] pc;
    logic            count_flag;
    logic [PC_W-1:0] from_PS;

    modport master (
        output jmp, jmp_nz, jmp_addr, dont_jmp,
        output NOPC8, NOPCF, NOPD8, NOPDF,
        input  pm_addr, pc, count_flag, from_PS
    );

    modport slave (
        input  jmp, jmp_nz, jmp_addr, dont_jmp,
        input  NOPC8, NOPCF, NOPD8, NOPDF,
        output pm_addr, pc, count_flag, from_PS
    );
endinterface

// File: rtl/program_sequencer_stall.sv
// Program sequencer with jump handling and multi-cycle stall
// NOPs that hold the pc while the decoder keeps its ir.
module program_sequencer_stall #(
    parameter int PC_W = 8
) (
    input logic                     clk,
    input logic                     sync_reset,
    program_sequencer_stall_if.slave bus
);
    typedef enum logic {
        RUN,
        STALL
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [3:0]      cnt;
    logic [3:0]      cnt_d;
    logic [3:0]      stall_len;
    logic            nop_any;
    logic            taken;
    logic            hold;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] next_addr;

    assign nop_any = bus.NOPC8 | bus.NOPCF | bus.NOPD8 | bus.NOPDF;
    assign taken   = bus.jmp | (bus.jmp_nz & ~bus.dont_jmp);
    assign target  = PC_W'({bus.jmp_addr, 4'h0});
    assign pc_inc  = pc_q + PC_W'(1);

    // Stall length minus one; the longest NOP wins when several fire.
    always_comb begin
        stall_len = 4'd0;
        if (bus.NOPDF) begin
            stall_len = 4'd14;
        end else if (bus.NOPD8) begin
            stall_len = 4'd6;
        end else if (bus.NOPCF) begin
            stall_len = 4'd2;
        end else if (bus.NOPC8) begin
            stall_len = 4'd0;
        end
    end

    // FSM next state, down-counter and hold request.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        hold    = 1'b0;
        unique case (state)
            RUN: begin
                if (nop_any) begin
                    hold    = 1'b1;
                    cnt_d   = stall_len;
                    state_d = STALL;
                end
            end
            STALL: begin
                if (cnt != 4'd0) begin
                    hold  = 1'b1;
                    cnt_d = cnt - 4'd1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
        if (sync_reset) begin
            hold = 1'b0;
        end
    end

    // Fetch address: reset, jumps, stall hold, then sequential.
    always_comb begin
        next_addr = pc_inc;
        if (sync_reset) begin
            next_addr = '0;
        end else if (taken) begin
            next_addr = target;
        end else if (hold) begin
            next_addr = pc_q;
        end
    end

    // Register pc and the stall FSM; reset forces RUN.
    always_ff @(posedge clk) begin
        pc_q <= next_addr;
        if (sync_reset) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    assign bus.pm_addr    = next_addr;
    assign bus.pc         = pc_q;
    assign bus.from_PS    = pc_q;
    assign bus.count_flag = hold;
endmodule

// File: tb/tb_program_sequencer_stall.sv
// Directed and randomized checks of the program sequencer
// against a cycle-level behavioural model.
module tb_program_sequencer_stall;
    logic clk;
    logic sync_reset;
    int   checks;
    int   failures;
    int   m_pc;
    int   rem;
    bit   gap;
    int   flag_hi;

    program_sequencer_stall_if #(.PC_W(8)) bus ();

    program_sequencer_stall #(.PC_W(8)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int nop_len();
        if (bus.NOPDF) return 15;
        if (bus.NOPD8) return 7;
        if (bus.NOPCF) return 3;
        if (bus.NOPC8) return 1;
        return 0;
    endfunction

    task automatic clr();
        sync_reset   = 1'b0;
        bus.jmp      = 1'b0;
        bus.jmp_nz   = 1'b0;
        bus.jmp_addr = 4'h0;
        bus.dont_jmp = 1'b0;
        bus.NOPC8    = 1'b0;
        bus.NOPCF    = 1'b0;
        bus.NOPD8    = 1'b0;
        bus.NOPDF    = 1'b0;
    endtask

    // One clock: check combinational outputs, clock, check pc.
    task automatic cycle(string tag);
        int n;
        int exp_pm;
        bit exp_flag;
        #3;
        if (sync_reset) begin
            exp_flag = 1'b0;
            exp_pm   = 0;
        end else begin
            n = nop_len();
            if (rem == 0 && !gap && n > 0) rem = n;
            exp_flag = (rem > 0);
            if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp))
                exp_pm = int'(bus.jmp_addr) * 16;
            else if (exp_flag)
                exp_pm = m_pc;
            else
                exp_pm = (m_pc + 1) % 256;
        end
        check({tag, ".flag"}, 32'(bus.count_flag), 32'(exp_flag));
        check({tag, ".pm"}, 32'(bus.pm_addr), 32'(exp_pm));
        if (bus.count_flag === 1'b1) flag_hi++;
        @(posedge clk);
        #1;
        if (sync_reset) begin
            rem = 0;
            gap = 1'b0;
        end else if (rem > 0) begin
            rem--;
            gap = (rem == 0);
        end else begin
            gap = 1'b0;
        end
        m_pc = exp_pm;
        check({tag, ".pc"}, 32'(bus.pc), 32'(m_pc));
        check({tag, ".dbg"}, 32'(bus.from_PS), 32'(m_pc));
    endtask

    task automatic jump_to(logic [3:0] a);
        bus.jmp      = 1'b1;
        bus.jmp_addr = a;
        cycle("jmp");
        clr();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_pc     = 0;
        rem      = 0;
        gap      = 1'b0;
        flag_hi  = 0;
        clr();

        sync_reset = 1'b1;
        bus.NOPDF  = 1'b1;
        bus.jmp    = 1'b1;
        cycle("rst0");
        cycle("rst1");
        check("rst_pc", 32'(bus.pc), 32'h0);
        clr();

        #3;
        check("first_fetch", 32'(bus.pm_addr), 32'h01);
        #0;
        @(posedge clk);
        #1;
        m_pc = 1;
        for (int i = 0; i < 4; i++) cycle("free");
        check("free5", 32'(bus.pc), 32'h05);

        jump_to(4'hF);
        for (int i = 0; i < 15; i++) cycle("upff");
        check("at_ff", 32'(bus.pc), 32'hFF);
        cycle("wrap");
        check("wrap0", 32'(bus.pc), 32'h00);

        jump_to(4'h1);
        bus.NOPC8 = 1'b1;
        flag_hi   = 0;
        cycle("c8a");
        check("c8_hold1", 32'(bus.pc), 32'h10);
        clr();
        cycle("c8b");
        check("c8_after", 32'(bus.pc), 32'h11);
        check("c8_flags", 32'(flag_hi), 32'd1);

        jump_to(4'h2);
        bus.NOPDF = 1'b1;
        flag_hi   = 0;
        for (int i = 0; i < 16; i++) cycle("df");
        clr();
        check("df_flags", 32'(flag_hi), 32'd15);
        check("df_after", 32'(bus.pc), 32'h21);
        cycle("df_post");

        jump_to(4'hA);
        check("jmp_a0", 32'(bus.pc), 32'hA0);
        bus.jmp_nz   = 1'b1;
        bus.jmp_addr = 4'h3;
        cycle("jnz_t");
        check("jnz_taken", 32'(bus.pc), 32'h30);
        bus.dont_jmp = 1'b1;
        cycle("jnz_n");
        check("jnz_not", 32'(bus.pc), 32'h31);
        clr();

        jump_to(4'h5);
        bus.NOPD8 = 1'b1;
        cycle("d8_1");
        clr();
        cycle("d8_2");
        cycle("d8_3");
        sync_reset = 1'b1;
        cycle("d8_rst");
        clr();
        check("d8_rst_pc", 32'(bus.pc), 32'h0);
        cycle("d8_run");
        check("d8_resume", 32'(bus.pc), 32'h1);

        bus.NOPCF = 1'b1;
        bus.NOPC8 = 1'b1;
        flag_hi   = 0;
        cycle("cf_1");
        clr();
        for (int i = 0; i < 3; i++) cycle("cf");
        check("cf_flags", 32'(flag_hi), 32'd3);

        jump_to(4'h6);
        bus.NOPD8 = 1'b1;
        cycle("djmp_1");
        clr();
        cycle("djmp_2");
        jump_to(4'h9);
        check("stall_jmp", 32'(bus.pc), 32'h90);
        for (int i = 0; i < 6; i++) cycle("djmp_t");

        for (int i = 0; i < 400; i++) begin
            sync_reset   = ($urandom_range(63) == 0);
            bus.jmp      = ($urandom_range(15) == 0);
            bus.jmp_nz   = ($urandom_range(7) == 0);
            bus.dont_jmp = 1'($urandom_range(1));
            bus.jmp_addr = 4'($urandom_range(15));
            bus.NOPC8    = ($urandom_range(15) == 0);
            bus.NOPCF    = ($urandom_range(15) == 0);
            bus.NOPD8    = ($urandom_range(15) == 0);
            bus.NOPDF    = ($urandom_range(23) == 0);
            cycle("rnd");
        end
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_sequencer_stall.md
PROGRAM_SEQUENCER_STALL -- requirements
Module: program_sequencer_stall

Interface
REQ-001 SHALL have parameter PC_W, default 8, meaning program counter and program memory address width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port sync_reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port jmp  input  1  unconditional jump decoded from the current instruction.
REQ-005 SHALL have port jmp_nz  input  1  conditional jump decoded from the current instruction; taken when dont_jmp=0.
REQ-006 SHALL have port jmp_addr  input  4  jump target nibble (ir_nibble from the instruction decoder).
REQ-007 SHALL have port dont_jmp  input  1  zero flag from the ALU; 1 suppresses jmp_nz.
REQ-008 SHALL have ports NOPC8, NOPCF, NOPD8, NOPDF  input  1 each  stall-NOP decodes from the instruction decoder.
REQ-009 SHALL have port pm_addr  output  PC_W  combinational program memory address for the next fetch.
REQ-010 SHALL have port pc  output  PC_W  registered program counter.
REQ-011 SHALL have port count_flag  output  1  combinational; high means the instruction decoder must hold ir.
REQ-012 SHALL have port from_PS  output  PC_W  debug copy of pc.

Function
REQ-013 pc SHALL load pm_addr on every rising clk edge.
REQ-014 pm_addr priority SHALL be: sync_reset -> 0; jmp -> {jmp_addr, 4'h0}; jmp_nz & !dont_jmp -> {jmp_addr, 4'h0}; count_flag -> pc (hold); otherwise pc+1.
REQ-015 pc+1 SHALL wrap modulo 2^PC_W (0xFF -> 0x00); no carry out.
REQ-016 The block SHALL contain a two-state FSM, RUN and STALL, plus a 4-bit down-counter cnt.
REQ-017 Extra hold cycles N SHALL be: NOPC8=1, NOPCF=3, NOPD8=7, NOPDF=15.
REQ-018 If several NOP inputs are high at once, priority SHALL be NOPDF > NOPD8 > NOPCF > NOPC8.
REQ-019 In RUN with any NOP input high, the block SHALL:
  - drive count_flag=1 combinationally;
  - load cnt=N-1 on the next edge;
  - move to STALL on the next edge.
REQ-020 In RUN with no NOP input high, count_flag SHALL be 0 and the FSM SHALL stay in RUN.
REQ-021 In STALL, count_flag SHALL equal (cnt != 0), and cnt SHALL decrement by 1 on each edge while nonzero.
REQ-022 In STALL with cnt==0, the FSM SHALL return to RUN on the next edge and SHALL ignore NOP inputs in that cycle (no retrigger).
REQ-023 A stall NOP SHALL therefore assert count_flag for exactly N consecutive cycles and occupy ir for N+1 cycles.
REQ-024 pc SHALL be held constant for the full duration that count_flag is high.
REQ-025 jmp or taken jmp_nz SHALL take effect in the same cycle it is asserted, with pc = target after one edge.
REQ-026 jmp or taken jmp_nz asserted while count_flag=1 SHALL still override the pc hold, and SHALL NOT alter the FSM or cnt.
REQ-027 from_PS SHALL equal pc at all times.

Reset
REQ-028 sync_reset high at an edge SHALL set pc=0, cnt=0 and state=RUN, overriding all other inputs, including during STALL.
REQ-029 While sync_reset is high, pm_addr SHALL be 0 and count_flag SHALL be 0.
REQ-030 The first fetch after reset release SHALL be from address 0x01.

Verification
REQ-031 Reset then free-run: after 5 clocks with no decodes -> pc=0x05; run from pc=0xFF -> next pc=0x00.
REQ-032 NOPC8 for one cycle at pc=0x10 -> count_flag high 1 cycle, pc holds 0x10 for 2 cycles, then 0x11.
REQ-033 NOPDF held high at pc=0x20 -> count_flag high exactly 15 consecutive cycles, no retrigger, then pc=0x21.
REQ-034 jmp=1 with jmp_addr=0xA -> pc=0xA0 next edge; jmp_nz=1, jmp_addr=0x3 -> pc=0x30 if dont_jmp=0, otherwise pc+1.
REQ-035 sync_reset asserted on the 4th cycle of a NOPD8 stall -> pc=0, count_flag=0, state RUN next cycle; normal increment resumes.
REQ-036 NOPCF and NOPC8 high together -> 3-cycle stall (NOPCF wins).
